// File: rtl/fifo_rd_unpacker.sv
// Read-side consumer of the async FIFO: issues reads, buffers up to two words,
// and serializes each word into OUT_WIDTH lanes (LSB lane first) on valid/ready.
module fifo_rd_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  RClk,
  input  logic                  PresetFull,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_read_en_out,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int R  = DATA_WIDTH / OUT_WIDTH;
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);

  generate
    if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
      $error("fifo_rd_unpacker: DATA_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic                       pend_q;
  logic [LW-1:0]              lane_q, lane_d;
  logic [CNT_WIDTH-1:0]       wcnt_q, wcnt_d;

  logic                       xfer, last_lane, pop;
  logic [R-1:0][OUT_WIDTH-1:0] cur_w;

  // A read in flight already owns a buffer slot, so it counts toward occupancy.
  assign fifo_read_en_out = !PresetFull && !fifo_empty_in &&
                            ((cnt_q + {1'b0, pend_q}) < 2'd2);

  assign cur_w      = buf_q[rd_ptr_q];
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = cur_w[lane_q];
  assign last_lane  = (lane_q == LAST_LANE);
  assign out_last   = out_valid && last_lane;
  assign xfer       = out_valid && out_ready;
  assign pop        = xfer && last_lane;
  assign word_count = wcnt_q;

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    wcnt_d   = wcnt_q;

    if (pend_q) begin
      buf_d[wr_ptr_q] = fifo_data_in;
      wr_ptr_d        = !wr_ptr_q;
    end

    if (xfer) begin
      if (last_lane) begin
        lane_d   = '0;
        rd_ptr_d = !rd_ptr_q;
        wcnt_d   = wcnt_q + CNT_WIDTH'(1);
      end else begin
        lane_d   = lane_q + LW'(1);
      end
    end

    case ({pend_q, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      buf_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      lane_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= fifo_read_en_out;
      lane_q   <= lane_d;
      wcnt_q   <= wcnt_d;
    end
  end

endmodule

// File: doc/fifo_rd_unpacker.md
# fifo_rd_unpacker

Read-side consumer placed directly downstream of the asynchronous FIFO, in the read clock domain. It drives the FIFO read enable, captures each word one cycle after the read, and buffers up to two words. It serializes each DATA_WIDTH word into OUT_WIDTH lanes on a valid/ready stream, least-significant lane first, and counts completed words.

## Interface
- DATA_WIDTH, 32, width of FIFO words.
- OUT_WIDTH, 8, output lane width; DATA_WIDTH % OUT_WIDTH == 0 is required (elaboration error otherwise); R = DATA_WIDTH/OUT_WIDTH.
- CNT_WIDTH, 16, width of the completed-word counter.

Ports:
- RClk  in  1  clock; all state updates on posedge.
- PresetFull  in  1  reset, asynchronous, active-high.
- fifo_data_in  in  DATA_WIDTH  FIFO read data; valid the cycle after a read is issued.
- fifo_empty_in  in  1  FIFO empty flag.
- fifo_read_en_out  out  1  FIFO read enable.
- out_data  out  OUT_WIDTH  current lane.
- out_valid  out  1  lane available.
- out_ready  in  1  downstream accepts the lane.
- out_last  out  1  current lane is lane R-1 of its word.
- word_count  out  CNT_WIDTH  words fully emitted, modulo 2^CNT_WIDTH.

## Operation
- State:
  - 2-entry word buffer: wr_ptr, rd_ptr (1 bit each), occupancy count 0..2.
  - pending flag: a read was issued last cycle.
  - lane index 0..R-1.
  - word_count.
- Read issue, combinational:
  - fifo_read_en_out = !PresetFull & !fifo_empty_in & (count + pending < 2).
  - Never asserted while the FIFO is empty. No over-read into a full buffer.
- Capture: when pending=1, fifo_data_in is written into buffer[wr_ptr] and wr_ptr toggles.
  - pending <= fifo_read_en_out every cycle.
- Output:
  - out_valid = (count != 0).
  - out_data = buffer[rd_ptr][lane*OUT_WIDTH +: OUT_WIDTH].
  - out_last = out_valid & (lane == R-1).
- Handshake: out_valid & out_ready is a transfer.
  - On transfer with lane < R-1: lane increments.
  - On transfer with lane == R-1: lane <= 0, rd_ptr toggles, word_count increments (wraps 2^CNT_WIDTH-1 -> 0).
- count update:
  - count <= count + capture - pop, where capture = pending and pop = last-lane transfer.
  - Simultaneous capture and pop leaves count unchanged. Both pointers move.
- out_data, out_last and out_valid stay stable while out_valid=1 and out_ready=0.
- Reset (PresetFull high, async):
  - count=0, pending=0, lane=0, pointers=0, word_count=0.
  - Outputs: out_valid=0, out_last=0, fifo_read_en_out=0, out_data=0 (buffer cleared).
  - Reset mid-word discards the buffered and in-flight words; a word read from the FIFO in the cycle reset asserts is lost.

## Timing
- Read issued in cycle N. FIFO presents data at the edge ending N. Captured at the edge ending N+1. out_valid=1 in cycle N+2. Latency from the read to the first lane is 2 cycles.
- Throughput:
  - R >= 2: one lane per cycle with out_ready held high and the FIFO non-empty. No bubbles after the first word.
  - R = 1: at most 2 words per 3 cycles, which is accepted.
- Deassertion of PresetFull is synchronous to RClk. The first read can issue in the first cycle after deassertion.
- fifo_empty_in is sampled combinationally. It must already be RClk-synchronous, which the upstream FIFO guarantees.

## Test plan
- Single word: reset, then 0xA1B2C3D4 in the FIFO, out_ready=1. Read in cycle 0, then lanes 0xD4, 0xC3, 0xB2, 0xA1 in cycles 2-5. out_last=1 only in cycle 5. word_count=1.
- Streaming: 8 words, out_ready=1. 32 consecutive lanes with no gap after the first. fifo_read_en_out is never high with fifo_empty_in=1. word_count=8.
- Backpressure: out_ready=0 for 10 cycles with 4 words queued. Exactly 2 reads are issued, then fifo_read_en_out=0. out_data holds 0xD4. On release, data order is preserved.
- Random out_ready (50%) with the FIFO randomly empty, 200 words. The scoreboard matches every lane in order. count never exceeds 2.
- Reset mid-word: assert PresetFull after lane 1 of a word. All outputs are 0 immediately (asynchronous). After release, the next FIFO word is emitted from lane 0.
- Wrap: CNT_WIDTH=4, 17 words. word_count reads 15 -> 0 -> 1.
